// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models multi-cycle latency with a
// down-counter and raises md_stall when a HI/LO-class instruction in D would
// collide with an in-flight or just-starting operation.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        res,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dz_q, dz_d;

  logic        is_mul, is_div, start;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, divisor, uq, ur, quot, rem;
  logic        is_signed;

  assign busy     = (cnt_q != '0);
  assign is_mul   = (E_md_op == OpMult) || (E_md_op == OpMultu);
  assign is_div   = (E_md_op == OpDiv) || (E_md_op == OpDivu);
  assign start    = (is_mul || is_div) && !busy;
  assign md_stall = D_md_use && (busy || start);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Shared multiplier and magnitude divider; signed forms fix up signs afterwards.
  always_comb begin
    is_signed = (E_md_op == OpMult) || (E_md_op == OpDiv);
    a_ext     = is_signed ? {{32{E_A[31]}}, E_A} : {32'h0, E_A};
    b_ext     = is_signed ? {{32{E_B[31]}}, E_B} : {32'h0, E_B};
    // Low 64 bits of the extended product are correct for both signednesses.
    prod      = a_ext * b_ext;
    a_mag     = (is_signed && E_A[31]) ? (32'h0 - E_A) : E_A;
    b_mag     = (is_signed && E_B[31]) ? (32'h0 - E_B) : E_B;
    // Divide-by-zero result is discarded; substitute 1 to keep the divider defined.
    divisor   = (b_mag == 32'h0) ? 32'h1 : b_mag;
    uq        = a_mag / divisor;
    ur        = a_mag % divisor;
    // 0x80000000 / -1 falls out as 0x80000000 since the magnitude wraps.
    quot      = (is_signed && (E_A[31] ^ E_B[31])) ? (32'h0 - uq) : uq;
    rem       = (is_signed && E_A[31]) ? (32'h0 - ur) : ur;
  end

  // Next-state: count down and commit while busy, else accept start or mthi/mtlo.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    if (busy) begin
      cnt_d = cnt_q - CntOne;
      if ((cnt_q == CntOne) && !dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start) begin
      if (is_mul) begin
        pend_hi_d = prod[63:32];
        pend_lo_d = prod[31:0];
        cnt_d     = MultLoad;
        dz_d      = 1'b0;
      end else begin
        pend_hi_d = rem;
        pend_lo_d = quot;
        cnt_d     = DivLoad;
        dz_d      = (E_B == 32'h0);
      end
    end else if (E_md_op == OpMthi) begin
      hi_d = E_A;
    end else if (E_md_op == OpMtlo) begin
      lo_d = E_A;
    end
  end

  // State registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the five-stage pipeline. It takes mult/multu/div/divu/mthi/mtlo from the E stage, owns the HI/LO registers, and models the multi-cycle latency with a busy counter. It drives the stall request that freezes F/D and bubbles E while a HI/LO-class instruction in D would collide with an in-flight operation. It sits beside the ALU in E; `md_stall` is ORed into the existing stall signal at the top level.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  pipeline clock, rising edge
- res  in  1  reset, asynchronous, active-high
- E_md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- E_A  in  32  forwarded rs value in E
- E_B  in  32  forwarded rt value in E
- D_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- md_stall  out  1  stall request to F/D/E control (combinational)
- hi  out  32  architectural HI (registered)
- lo  out  32  architectural LO (registered)

## Operation
- Define `start` = E_md_op ∈ {1,2,3,4} and !busy.
- Define `md_stall` = D_md_use & (busy | start). The E register is cleared on stall, so each E-stage md op is presented for exactly one cycle.
- On a clock edge with `start`:
  - Compute the 64-bit result from E_A/E_B into pending registers pend_hi/pend_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; set busy.
- Arithmetic:
  - mult: signed 32×32→64. pend_hi = [63:32], pend_lo = [31:0].
  - multu: unsigned 32×32→64, same split.
  - div: signed, truncating toward zero. pend_lo = quotient; pend_hi = remainder, which takes the sign of the dividend.
  - divu: unsigned. pend_lo = quotient, pend_hi = remainder.
  - div/divu with E_B == 0: the counter and busy sequence runs normally, but no commit occurs at the end; HI/LO keep their old values.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wrap).
- Busy phase:
  - The counter decrements by 1 each edge while busy.
  - On the edge where the counter goes 1→0, pend_hi/pend_lo are written to hi/lo (unless flagged div-by-zero) and busy clears.
- mthi/mtlo, when !busy: write E_A to hi (op 5) or lo (op 6) at that edge. They are single-cycle and do not set busy.
- Any md op (1–6) arriving while busy is ignored: no state change. The stall protocol makes this unreachable; verification checks it anyway.
- mfhi/mflo reads are combinational from `hi`/`lo` by the E-stage result mux, outside this block.

## Timing
- Reset (async, immediate): hi = 0, lo = 0, busy = 0, counter = 0, pending registers = 0. md_stall then equals D_md_use & start.
- Reset asserted mid-operation aborts the operation; no commit occurs after reset deasserts.
- Multiply timeline, with start sampled at the edge ending cycle t:
  - busy = 1 in cycles t+1 … t+MULT_CYCLES.
  - hi/lo hold new values from cycle t+MULT_CYCLES+1, where busy = 0.
  - Divide uses DIV_CYCLES the same way.
- md_stall is asserted:
  - in cycle t itself if D_md_use = 1 (covers back-to-back mult then mflo);
  - in every busy cycle where D_md_use = 1.
- It drops in the first cycle with busy = 0. An mflo in D then advances and reads the committed lo in E.
- A new start may occur in the same cycle busy is 0 after commit; there is no dead cycle.
- A non-md instruction in D never stalls, whether or not busy is set.
- mthi in E with mfhi in D: no stall. hi updates at the edge, and mfhi reaches E in the next cycle and sees the new value.

## Test plan
- mult E_A = 0xFFFFFFFD (−3), E_B = 5 → busy for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; busy = 0 in cycle t+6.
- multu 0xFFFFFFFF × 2 → hi = 0x00000001, lo = 0xFFFFFFFE. div 0xFFFFFFF9 (−7) / 2 → after 10 busy cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu 7 / 0 with prior hi = 0x11, lo = 0x22 → busy for 10 cycles, then hi/lo are still 0x11/0x22.
- mult in E with D_md_use = 1 for 8 cycles → md_stall = 1 for cycles t … t+5, 0 at t+6. With D_md_use = 0, md_stall is 0 throughout.
- mthi E_A = 0xDEADBEEF, next cycle mtlo E_A = 0x12345678 → hi/lo update on consecutive edges, busy stays 0, md_stall stays 0.
- Start div, assert res at busy cycle 4 → hi = lo = 0 and busy = 0 immediately (before the next edge). After release, no commit occurs, and a fresh mult runs normally.
